// File: rtl/lc3_mem_responder_if.sv
// LC-3 memory bus: active-low SRAM strobes, address/data from the CPU,
// registered read data and valid flag back from the memory side.
interface lc3_mem_responder_if;
    logic [15:0] ADDR;
    logic [15:0] Data_from_CPU;
    logic        Mem_CE;
    logic        Mem_UB;
    logic        Mem_LB;
    logic        Mem_OE;
    logic        Mem_WE;
    logic [15:0] Data_to_CPU;
    logic        Data_valid;

    modport master (
        output ADDR, Data_from_CPU,
        output Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE,
        input  Data_to_CPU, Data_valid
    );

    modport slave (
        input  ADDR, Data_from_CPU,
        input  Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE,
        output Data_to_CPU, Data_valid
    );
endinterface

// File: rtl/lc3_mem_responder.sv
// Memory-side responder for the LC-3 strobe bus: on-chip RAM with
// fixed-latency reads, byte-masked single-shot writes and one I/O word.
module lc3_mem_responder #(
    parameter int          ADDR_W   = 10,
    parameter int          READ_LAT = 1,
    parameter logic [15:0] IO_ADDR  = 16'hFFFF
) (
    input  logic                   Clk,
    input  logic                   Reset,
    lc3_mem_responder_if.slave     bus,
    input  logic [15:0]            Switches,
    output logic [15:0]            HEX_out
);

    typedef enum logic [1:0] {
        IDLE,
        RD_WAIT,
        RD_HOLD,
        WR_HOLD
    } state_t;

    localparam bit         LAT1     = (READ_LAT == 1);
    localparam logic [1:0] CNT_LOAD = 2'(READ_LAT - 1);

    state_t      state, state_d;
    logic [1:0]  cnt, cnt_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] dout_d;
    logic        valid_d;
    logic [15:0] hex_d;
    logic        commit;
    logic        start;
    logic        rd_req, wr_req;
    logic        is_io;
    logic [15:0] rd_word;

    logic [15:0] mem [0:(1 << ADDR_W) - 1];

    assign wr_req  = !bus.Mem_CE && !bus.Mem_WE;
    assign rd_req  = !bus.Mem_CE && !bus.Mem_OE && bus.Mem_WE;
    assign is_io   = (bus.ADDR == IO_ADDR);
    assign rd_word = is_io ? Switches : mem[bus.ADDR[ADDR_W-1:0]];

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state           <= IDLE;
            cnt             <= 2'd0;
            addr_q          <= 16'h0000;
            bus.Data_to_CPU <= 16'h0000;
            bus.Data_valid  <= 1'b0;
            HEX_out         <= 16'h0000;
        end else begin
            state           <= state_d;
            cnt             <= cnt_d;
            addr_q          <= addr_d;
            bus.Data_to_CPU <= dout_d;
            bus.Data_valid  <= valid_d;
            HEX_out         <= hex_d;
        end
    end

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        addr_d  = addr_q;
        dout_d  = bus.Data_to_CPU;
        valid_d = 1'b0;
        commit  = 1'b0;
        start   = 1'b0;

        unique case (state)
            IDLE: start = 1'b1;
            RD_WAIT: begin
                if (wr_req || (rd_req && bus.ADDR != addr_q)) begin
                    start = 1'b1;
                end else if (!rd_req) begin
                    state_d = IDLE;
                    cnt_d   = 2'd0;
                end else if (cnt <= 2'd1) begin
                    cnt_d   = 2'd0;
                    dout_d  = rd_word;
                    valid_d = 1'b1;
                    state_d = RD_HOLD;
                end else begin
                    cnt_d = cnt - 2'd1;
                end
            end
            RD_HOLD: begin
                if (rd_req && bus.ADDR == addr_q) valid_d = 1'b1;
                else start = 1'b1;
            end
            WR_HOLD: begin
                if (!wr_req) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Shared request decode for IDLE and for restarts out of a read
        if (start) begin
            state_d = IDLE;
            cnt_d   = 2'd0;
            if (wr_req) begin
                commit  = 1'b1;
                state_d = WR_HOLD;
            end else if (rd_req) begin
                addr_d = bus.ADDR;
                if (LAT1) begin
                    dout_d  = rd_word;
                    valid_d = 1'b1;
                    state_d = RD_HOLD;
                end else begin
                    cnt_d   = CNT_LOAD;
                    state_d = RD_WAIT;
                end
            end
        end
    end

    always_comb begin
        hex_d = HEX_out;
        if (commit && is_io) begin
            if (!bus.Mem_UB) hex_d[15:8] = bus.Data_from_CPU[15:8];
            if (!bus.Mem_LB) hex_d[7:0]  = bus.Data_from_CPU[7:0];
        end
    end

    // RAM is deliberately left out of reset; an edge under Reset never commits
    always_ff @(posedge Clk) begin
        if (!Reset && commit && !is_io) begin
            if (!bus.Mem_UB)
                mem[bus.ADDR[ADDR_W-1:0]][15:8] <= bus.Data_from_CPU[15:8];
            if (!bus.Mem_LB)
                mem[bus.ADDR[ADDR_W-1:0]][7:0] <= bus.Data_from_CPU[7:0];
        end
    end

endmodule

// File: tb/tb_lc3_mem_responder.sv
// Bench for lc3_mem_responder: READ_LAT=1 and READ_LAT=3 instances share
// one stimulus stream; reads are checked through per-instance scoreboards.
module tb_lc3_mem_responder;

    logic        Clk;
    logic        Reset;
    logic [15:0] Switches;
    logic [15:0] hex1, hex3;

    lc3_mem_responder_if b1 ();
    lc3_mem_responder_if b3 ();

    assign b3.ADDR          = b1.ADDR;
    assign b3.Data_from_CPU = b1.Data_from_CPU;
    assign b3.Mem_CE        = b1.Mem_CE;
    assign b3.Mem_UB        = b1.Mem_UB;
    assign b3.Mem_LB        = b1.Mem_LB;
    assign b3.Mem_OE        = b1.Mem_OE;
    assign b3.Mem_WE        = b1.Mem_WE;

    lc3_mem_responder #(.ADDR_W(10), .READ_LAT(1), .IO_ADDR(16'hFFFF)) dut1 (
        .Clk      (Clk),
        .Reset    (Reset),
        .bus      (b1),
        .Switches (Switches),
        .HEX_out  (hex1)
    );

    lc3_mem_responder #(.ADDR_W(10), .READ_LAT(3), .IO_ADDR(16'hFFFF)) dut3 (
        .Clk      (Clk),
        .Reset    (Reset),
        .bus      (b3),
        .Switches (Switches),
        .HEX_out  (hex3)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int n_pass  = 0;
    int n_total = 0;

    logic [15:0] q1[$];
    logic [15:0] q3[$];
    bit          mon1_en = 1'b1;
    bit          mon3_en = 1'b1;
    logic        v1_prev = 1'b0;
    logic        v3_prev = 1'b0;

    task automatic chk(input string name, input logic [15:0] act,
                       input logic [15:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        else
            n_pass++;
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic bus_idle();
        b1.Mem_CE = 1'b1;
        b1.Mem_OE = 1'b1;
        b1.Mem_WE = 1'b1;
        b1.Mem_UB = 1'b1;
        b1.Mem_LB = 1'b1;
    endtask

    task automatic set_read(input logic [15:0] a);
        b1.ADDR   = a;
        b1.Mem_CE = 1'b0;
        b1.Mem_OE = 1'b0;
        b1.Mem_WE = 1'b1;
        b1.Mem_UB = 1'b0;
        b1.Mem_LB = 1'b0;
    endtask

    // Scoreboard: each rising Data_valid pops one expected word
    always @(posedge Clk) begin
        #1;
        if (Reset) begin
            v1_prev = 1'b0;
            v3_prev = 1'b0;
        end else begin
            if (mon1_en && b1.Data_valid && !v1_prev) begin
                if (q1.size() == 0) chk("lat1_spurious_valid", b1.Data_to_CPU, 16'hxxxx);
                else chk("lat1_read_data", b1.Data_to_CPU, q1.pop_front());
            end
            if (mon3_en && b3.Data_valid && !v3_prev) begin
                if (q3.size() == 0) chk("lat3_spurious_valid", b3.Data_to_CPU, 16'hxxxx);
                else chk("lat3_read_data", b3.Data_to_CPU, q3.pop_front());
            end
            v1_prev = b1.Data_valid;
            v3_prev = b3.Data_valid;
        end
    end

    typedef struct {
        bit          is_wr;
        logic [15:0] addr;
        logic [15:0] data;
        logic        ub_n;
        logic        lb_n;
        logic [15:0] exp;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(bit w, logic [15:0] a, logic [15:0] d,
                                logic ub, logic lb, logic [15:0] e);
        vec_t v;
        v.is_wr = w;
        v.addr  = a;
        v.data  = d;
        v.ub_n  = ub;
        v.lb_n  = lb;
        v.exp   = e;
        return v;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit hit");
        $fatal(1);
    end

    initial begin
        // Writes: exp is HEX_out after the commit; reads: exp is the word
        vt.push_back(mk(1, 16'h0003, 16'h1234, 0, 0, 16'h0000));
        vt.push_back(mk(0, 16'h0003, 16'h0000, 0, 0, 16'h1234));
        vt.push_back(mk(1, 16'h0010, 16'hABCD, 0, 1, 16'h0000));
        vt.push_back(mk(1, 16'h0010, 16'h5678, 1, 0, 16'h0000));
        vt.push_back(mk(0, 16'h0010, 16'h0000, 0, 0, 16'hAB78));
        vt.push_back(mk(1, 16'h0001, 16'h1111, 0, 0, 16'h0000));
        vt.push_back(mk(1, 16'h0002, 16'h2222, 0, 0, 16'h0000));
        vt.push_back(mk(0, 16'h0401, 16'h0000, 0, 0, 16'h1111));
        vt.push_back(mk(1, 16'h0003, 16'hFFFF, 1, 1, 16'h0000));
        vt.push_back(mk(0, 16'h0003, 16'h0000, 0, 0, 16'h1234));
        vt.push_back(mk(1, 16'h03FF, 16'h7777, 0, 0, 16'h0000));
        vt.push_back(mk(1, 16'hFFFF, 16'hBEEF, 0, 0, 16'hBEEF));
        vt.push_back(mk(0, 16'h03FF, 16'h0000, 0, 0, 16'h7777));
        vt.push_back(mk(0, 16'hFFFF, 16'h0000, 0, 0, 16'h00C3));
        vt.push_back(mk(1, 16'hFFFF, 16'h1234, 1, 0, 16'hBE34));
        vt.push_back(mk(0, 16'h0002, 16'h0000, 0, 0, 16'h2222));

        Reset            = 1'b1;
        Switches         = 16'h00C3;
        b1.ADDR          = 16'h0000;
        b1.Data_from_CPU = 16'h0000;
        bus_idle();
        step();
        step();
        chk("rst_data1",  b1.Data_to_CPU, 16'h0000);
        chk("rst_valid1", {15'd0, b1.Data_valid}, 16'h0000);
        chk("rst_hex1",   hex1, 16'h0000);
        chk("rst_data3",  b3.Data_to_CPU, 16'h0000);
        chk("rst_valid3", {15'd0, b3.Data_valid}, 16'h0000);
        chk("rst_hex3",   hex3, 16'h0000);
        #3 Reset = 1'b0;
        step();

        foreach (vt[i]) begin
            if (vt[i].is_wr) begin
                b1.ADDR          = vt[i].addr;
                b1.Data_from_CPU = vt[i].data;
                b1.Mem_CE        = 1'b0;
                b1.Mem_WE        = 1'b0;
                b1.Mem_OE        = 1'b1;
                b1.Mem_UB        = vt[i].ub_n;
                b1.Mem_LB        = vt[i].lb_n;
                step();
                chk($sformatf("wr%0d_hex1", i), hex1, vt[i].exp);
                chk($sformatf("wr%0d_hex3", i), hex3, vt[i].exp);
                bus_idle();
                step();
            end else begin
                q1.push_back(vt[i].exp);
                set_read(vt[i].addr);
                step();
                chk($sformatf("rd%0d_valid", i), {15'd0, b1.Data_valid}, 16'h0001);
                step();
                chk($sformatf("rd%0d_hold", i), {15'd0, b1.Data_valid}, 16'h0001);
                bus_idle();
                step();
                chk($sformatf("rd%0d_drop", i), {15'd0, b1.Data_valid}, 16'h0000);
            end
        end

        // Held WE with OE also low: only the first data word lands
        b1.ADDR   = 16'h0020;
        b1.Mem_CE = 1'b0;
        b1.Mem_WE = 1'b0;
        b1.Mem_OE = 1'b0;
        b1.Mem_UB = 1'b0;
        b1.Mem_LB = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            b1.Data_from_CPU = 16'(k);
            step();
        end
        bus_idle();
        step();
        q1.push_back(16'h0001);
        set_read(16'h0020);
        step();
        step();
        bus_idle();
        step();

        // READ_LAT=3 corner cases
        mon1_en = 1'b0;
        q3.push_back(16'h1111);
        set_read(16'h0401);
        step();
        chk("lat3_e0", {15'd0, b3.Data_valid}, 16'h0000);
        step();
        chk("lat3_e1", {15'd0, b3.Data_valid}, 16'h0000);
        step();
        chk("lat3_e2", {15'd0, b3.Data_valid}, 16'h0001);
        bus_idle();
        step();
        chk("lat3_drop", {15'd0, b3.Data_valid}, 16'h0000);

        set_read(16'h0003);
        step();
        bus_idle();
        for (int k = 0; k < 4; k++) begin
            step();
            chk("abort_valid", {15'd0, b3.Data_valid}, 16'h0000);
            chk("abort_data", b3.Data_to_CPU, 16'h1111);
        end

        set_read(16'h0001);
        step();
        b1.ADDR = 16'h0002;
        q3.push_back(16'h2222);
        step();
        chk("chg_c0", {15'd0, b3.Data_valid}, 16'h0000);
        step();
        chk("chg_c1", {15'd0, b3.Data_valid}, 16'h0000);
        step();
        chk("chg_c2", {15'd0, b3.Data_valid}, 16'h0001);
        bus_idle();
        step();

        // Asynchronous reset while the LAT3 instance sits in RD_WAIT
        set_read(16'h0002);
        step();
        #3 Reset = 1'b1;
        #1;
        chk("arst_valid3", {15'd0, b3.Data_valid}, 16'h0000);
        chk("arst_data3",  b3.Data_to_CPU, 16'h0000);
        chk("arst_data1",  b1.Data_to_CPU, 16'h0000);
        chk("arst_hex1",   hex1, 16'h0000);
        chk("arst_hex3",   hex3, 16'h0000);
        bus_idle();
        step();
        #3 Reset = 1'b0;
        step();

        mon1_en = 1'b1;
        q1.push_back(16'h1234);
        q3.push_back(16'h1234);
        set_read(16'h0003);
        step();
        step();
        step();
        chk("post_rst_valid3", {15'd0, b3.Data_valid}, 16'h0001);
        bus_idle();
        step();
        step();

        chk("q1_drained", 16'(q1.size()), 16'h0000);
        chk("q3_drained", 16'(q3.size()), 16'h0000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
